// File: rtl/expl_axi_pkg.sv
// Shared types and AXI constants for the explicit AXI master port arbiter.
package expl_axi_pkg;

    localparam int unsigned EXPL_ADDR_W = 32;
    localparam int unsigned EXPL_DATA_W = 32;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP
    } state_e;

endpackage

// File: rtl/expl_axi_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; owns the last-served pointer, which moves only on grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_c,
    output logic       gnt_idx_c
);

    logic ptr_q, ptr_d;

    // Contention goes to the requester not served last; a lone request always wins.
    always_comb begin
        gnt_c     = 2'b00;
        gnt_idx_c = 1'b0;
        ptr_d     = ptr_q;
        if (req_i == 2'b11) begin
            gnt_idx_c = ~ptr_q;
        end else begin
            gnt_idx_c = req_i[1];
        end
        if (en_i && (|req_i)) begin
            gnt_c[gnt_idx_c] = 1'b1;
            ptr_d            = gnt_idx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/expl_axi_arbiter.sv
// Arbitrates two single-word requesters onto one AXI3 master, one single-beat transaction at a time.
module expl_axi_arbiter
    import expl_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = EXPL_ADDR_W,
    parameter int unsigned DATA_W = EXPL_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_W-1:0]     req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [DATA_W/8-1:0]   req0_wstrb,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_W-1:0]     req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [DATA_W/8-1:0]   req1_wstrb,
    output logic                  rsp0_valid,
    output logic [DATA_W-1:0]     rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  expl_axi_arvalid,
    input  logic                  expl_axi_arready,
    output logic [ADDR_W-1:0]     expl_axi_araddr,
    output logic [3:0]            expl_axi_arlen,
    output logic [2:0]            expl_axi_arsize,
    output logic [1:0]            expl_axi_arburst,
    output logic [1:0]            expl_axi_arlock,
    output logic [3:0]            expl_axi_arcache,
    output logic [2:0]            expl_axi_arprot,
    output logic                  expl_axi_awvalid,
    input  logic                  expl_axi_awready,
    output logic [ADDR_W-1:0]     expl_axi_awaddr,
    output logic [3:0]            expl_axi_awlen,
    output logic [2:0]            expl_axi_awsize,
    output logic [1:0]            expl_axi_awburst,
    output logic [1:0]            expl_axi_awlock,
    output logic [3:0]            expl_axi_awcache,
    output logic [2:0]            expl_axi_awprot,
    output logic                  expl_axi_wvalid,
    input  logic                  expl_axi_wready,
    output logic [DATA_W-1:0]     expl_axi_wdata,
    output logic [DATA_W/8-1:0]   expl_axi_wstrb,
    output logic                  expl_axi_wlast,
    input  logic                  expl_axi_rvalid,
    output logic                  expl_axi_rready,
    input  logic [DATA_W-1:0]     expl_axi_rdata,
    input  logic [1:0]            expl_axi_rresp,
    input  logic                  expl_axi_rlast,
    input  logic                  expl_axi_bvalid,
    output logic                  expl_axi_bready,
    input  logic [1:0]            expl_axi_bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                gnt_idx_q, gnt_idx_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;

    logic [1:0]          arb_gnt_c;
    logic                arb_idx_c;
    logic                sel_write_c;
    logic                done_c;
    logic                done_err_c;
    logic [DATA_W-1:0]   done_data_c;
    logic                rlast_unused;

    assign rlast_unused = expl_axi_rlast;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({req1_valid, req0_valid}),
        .en_i      (state_q == ST_IDLE),
        .gnt_c     (arb_gnt_c),
        .gnt_idx_c (arb_idx_c)
    );

    assign sel_write_c = arb_idx_c ? req1_write : req0_write;

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        gnt_idx_d    = gnt_idx_q;
        arvalid_d    = arvalid_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = rsp_err_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        done_c       = 1'b0;
        done_err_c   = 1'b0;
        done_data_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt_c) begin
                    gnt_idx_d = arb_idx_c;
                    write_d   = sel_write_c;
                    addr_d    = arb_idx_c ? req1_addr  : req0_addr;
                    wdata_d   = arb_idx_c ? req1_wdata : req0_wdata;
                    wstrb_d   = arb_idx_c ? req1_wstrb : req0_wstrb;
                    arvalid_d = ~sel_write_c;
                    awvalid_d = sel_write_c;
                    wvalid_d  = sel_write_c;
                    state_d   = sel_write_c ? ST_WADDR : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (expl_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (expl_axi_rvalid) begin
                    done_c      = 1'b1;
                    done_err_c  = (expl_axi_rresp != RESP_OKAY);
                    done_data_c = expl_axi_rdata;
                    state_d     = ST_IDLE;
                end
            end
            ST_WADDR: begin
                // AW and W complete independently; leave once neither is still pending.
                if (expl_axi_awready) awvalid_d = 1'b0;
                if (expl_axi_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || expl_axi_awready) && (!wvalid_q || expl_axi_wready)) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (expl_axi_bvalid) begin
                    done_c     = 1'b1;
                    done_err_c = (expl_axi_bresp != RESP_OKAY);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done_c) begin
            rsp_valid_d[gnt_idx_q] = 1'b1;
            rsp_err_d[gnt_idx_q]   = done_err_c;
            if (gnt_idx_q) rsp1_rdata_d = done_data_c;
            else           rsp0_rdata_d = done_data_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            gnt_idx_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            gnt_idx_q    <= gnt_idx_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign req0_ready = arb_gnt_c[0];
    assign req1_ready = arb_gnt_c[1];

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

    assign expl_axi_arvalid = arvalid_q;
    assign expl_axi_araddr  = addr_q;
    assign expl_axi_arlen   = LEN_SINGLE;
    assign expl_axi_arsize  = SIZE_WORD;
    assign expl_axi_arburst = BURST_INCR;
    assign expl_axi_arlock  = 2'b00;
    assign expl_axi_arcache = 4'b0000;
    assign expl_axi_arprot  = 3'b000;

    assign expl_axi_awvalid = awvalid_q;
    assign expl_axi_awaddr  = addr_q;
    assign expl_axi_awlen   = LEN_SINGLE;
    assign expl_axi_awsize  = SIZE_WORD;
    assign expl_axi_awburst = BURST_INCR;
    assign expl_axi_awlock  = 2'b00;
    assign expl_axi_awcache = 4'b0000;
    assign expl_axi_awprot  = 3'b000;

    assign expl_axi_wvalid = wvalid_q;
    assign expl_axi_wdata  = wdata_q;
    assign expl_axi_wstrb  = wstrb_q;
    assign expl_axi_wlast  = wvalid_q;

    assign expl_axi_rready = (state_q == ST_RDATA);
    assign expl_axi_bready = (state_q == ST_WRESP);

endmodule

// File: tb/tb_expl_axi_arbiter.sv
// Directed self-checking bench for expl_axi_arbiter with hand-computed expectations.
module tb_expl_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_wstrb;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_wstrb;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        arvalid, arready, awvalid, awready, wvalid, wready, wlast;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        rvalid, rready, rlast, bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    expl_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .expl_axi_arvalid(arvalid), .expl_axi_arready(arready), .expl_axi_araddr(araddr),
        .expl_axi_arlen(arlen), .expl_axi_arsize(arsize), .expl_axi_arburst(arburst),
        .expl_axi_arlock(arlock), .expl_axi_arcache(arcache), .expl_axi_arprot(arprot),
        .expl_axi_awvalid(awvalid), .expl_axi_awready(awready), .expl_axi_awaddr(awaddr),
        .expl_axi_awlen(awlen), .expl_axi_awsize(awsize), .expl_axi_awburst(awburst),
        .expl_axi_awlock(awlock), .expl_axi_awcache(awcache), .expl_axi_awprot(awprot),
        .expl_axi_wvalid(wvalid), .expl_axi_wready(wready), .expl_axi_wdata(wdata),
        .expl_axi_wstrb(wstrb), .expl_axi_wlast(wlast),
        .expl_axi_rvalid(rvalid), .expl_axi_rready(rready), .expl_axi_rdata(rdata),
        .expl_axi_rresp(rresp), .expl_axi_rlast(rlast),
        .expl_axi_bvalid(bvalid), .expl_axi_bready(bready), .expl_axi_bresp(bresp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
        slave_idle();
        cyc(); cyc();
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        cyc();
        rst = 1'b0;

        // Single read from requester 0, zero-wait slave.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h1000_0040;
        #1;
        check("rd_req0_ready", req0_ready, 1);
        check("rd_req1_ready", req1_ready, 0);
        cyc();
        req0_valid = 1'b0; arready = 1'b1;
        #1;
        check("rd_arvalid", arvalid, 1);
        check("rd_araddr", araddr, 32'h1000_0040);
        check("rd_arlen", arlen, 0);
        check("rd_arsize", arsize, 2);
        check("rd_arburst", arburst, 1);
        check("rd_rready_early", rready, 0);
        check("rd_req0_ready_busy", req0_ready, 0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        #1;
        check("rd_rready", rready, 1);
        check("rd_arvalid_drop", arvalid, 0);
        cyc();
        rvalid = 1'b0;
        #1;
        check("rd_rsp0_valid", rsp0_valid, 1);
        check("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        check("rd_rsp0_err", rsp0_err, 0);
        check("rd_rsp1_valid", rsp1_valid, 0);
        cyc();
        #1;
        check("rd_rsp0_pulse_end", rsp0_valid, 0);

        // Write from requester 1; W completes two cycles before AW.
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h1000_0080;
        req1_wdata = 32'h1234_5678; req1_wstrb = 4'b0011;
        #1;
        check("wr_req1_ready", req1_ready, 1);
        check("wr_req0_ready", req0_ready, 0);
        cyc();
        req1_valid = 1'b0; wready = 1'b1;
        #1;
        check("wr_awvalid", awvalid, 1);
        check("wr_wvalid", wvalid, 1);
        check("wr_wlast", wlast, 1);
        check("wr_awaddr", awaddr, 32'h1000_0080);
        check("wr_wdata", wdata, 32'h1234_5678);
        check("wr_wstrb", wstrb, 4'b0011);
        check("wr_awsize", awsize, 2);
        cyc();
        wready = 1'b0;
        #1;
        check("wr_wvalid_drop", wvalid, 0);
        check("wr_awvalid_hold1", awvalid, 1);
        check("wr_bready_early", bready, 0);
        cyc();
        awready = 1'b1;
        #1;
        check("wr_awvalid_hold2", awvalid, 1);
        check("wr_awaddr_stable", awaddr, 32'h1000_0080);
        cyc();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        #1;
        check("wr_awvalid_drop", awvalid, 0);
        check("wr_bready", bready, 1);
        cyc();
        bvalid = 1'b0;
        #1;
        check("wr_rsp1_valid", rsp1_valid, 1);
        check("wr_rsp1_err", rsp1_err, 0);
        check("wr_rsp1_rdata", rsp1_rdata, 0);
        check("wr_rsp0_valid", rsp0_valid, 0);
        cyc();
        #1;
        check("wr_rsp1_once", rsp1_valid, 0);

        // Contention: both requesters always valid, zero-wait read slave.
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0000_1000;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0000_2000;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hA5A5_0000; rresp = 2'b00;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("ct_req0_ready", req0_ready, ((i % 2) == 0) ? 1 : 0);
            check("ct_req1_ready", req1_ready, ((i % 2) == 1) ? 1 : 0);
            check("ct_rsp0_valid", rsp0_valid, (i > 0 && ((i - 1) % 2) == 0) ? 1 : 0);
            check("ct_rsp1_valid", rsp1_valid, (i > 0 && ((i - 1) % 2) == 1) ? 1 : 0);
            cyc();
            #1;
            check("ct_araddr", araddr, ((i % 2) == 0) ? 32'h0000_1000 : 32'h0000_2000);
            check("ct_no_ready", {req1_ready, req0_ready}, 2'b00);
            cyc();
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("ct_last_rsp1", rsp1_valid, 1);
        check("ct_last_rdata", rsp1_rdata, 32'hA5A5_0000);

        // Error responses with an always-valid slave; stray beats must not be taken.
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b11;
        rresp = 2'b10; rdata = 32'h1111_2222;
        cyc();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0000_3000;
        #1;
        check("er_rd_grant", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0000_3004;
        req0_wdata = 32'hCAFE_0001; req0_wstrb = 4'hF;
        #1;
        check("er_rd_rsp_valid", rsp0_valid, 1);
        check("er_rd_err", rsp0_err, 1);
        check("er_rd_rdata", rsp0_rdata, 32'h1111_2222);
        check("er_wr_grant", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0000_3008;
        rresp = 2'b00; rdata = 32'h3333_4444;
        #1;
        check("er_wr_rsp_valid", rsp0_valid, 1);
        check("er_wr_err", rsp0_err, 1);
        check("er_wr_rdata", rsp0_rdata, 0);
        cyc();
        req0_valid = 1'b0;
        cyc();
        cyc();
        #1;
        check("er_ok_rsp_valid", rsp0_valid, 1);
        check("er_ok_err", rsp0_err, 0);
        check("er_ok_rdata", rsp0_rdata, 32'h3333_4444);
        check("er_rsp1_quiet", rsp1_valid, 0);

        // Wait states: arready held off for five cycles.
        slave_idle();
        cyc();
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h2000_0010;
        #1;
        check("ws_grant", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("ws_arvalid_hold", arvalid, 1);
            check("ws_araddr_stable", araddr, 32'h2000_0010);
            check("ws_rready_low", rready, 0);
            cyc();
        end
        arready = 1'b1;
        cyc();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        #1;
        check("ws_rready", rready, 1);
        check("ws_arvalid_drop", arvalid, 0);
        cyc();
        rvalid = 1'b0;
        #1;
        check("ws_rsp1_valid", rsp1_valid, 1);
        check("ws_rsp1_rdata", rsp1_rdata, 32'h0BAD_F00D);

        // Reset mid-write after serving requester 0 last.
        cyc();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0000_4000;
        req0_wdata = 32'h5555_AAAA; req0_wstrb = 4'hF;
        #1;
        check("rs_grant", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        #1;
        check("rs_awvalid_pre", awvalid, 1);
        rst = 1'b1;
        cyc();
        #1;
        check("rs_awvalid", awvalid, 0);
        check("rs_wvalid", wvalid, 0);
        check("rs_arvalid", arvalid, 0);
        check("rs_bready", bready, 0);
        check("rs_rsp0_valid", rsp0_valid, 0);
        rst = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0000_5000;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0000_6000;
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        check("rs_req0_first", req0_ready, 1);
        check("rs_req1_wait", req1_ready, 0);
        check("rs_no_stray_rsp", rsp0_valid, 0);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'h7777_8888;
        #1;
        check("rs_araddr", araddr, 32'h0000_5000);
        cyc();
        cyc();
        #1;
        check("rs_rsp0_valid_after", rsp0_valid, 1);
        check("rs_rsp0_rdata", rsp0_rdata, 32'h7777_8888);
        check("rs_rsp1_valid_after", rsp1_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
